ahb_slave_if: RTL

AHB-Lite slave front end of the AHB-to-APB bridge; sits directly downstream of the AHB master and feeds the bridge's APB control FSM. Qualifies each address phase and decodes it into a one-hot peripheral select. Pipelines address, write data and direction by two stages for the APB FSM. Generates the two-cycle AHB ERROR response for unmapped or illegal transfers and otherwise forwards the FSM's ready/read data back to the master.

---
 rtl/ahb_slave_if.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: address qualification, region decode,
// two-stage address/data/direction pipeline and the two-cycle ERROR response.
// Optional feature: define ALIGN_CHECK_EN to reject misaligned halfword/word transfers.
module ahb_slave_if #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned REGION_LOG2 = 26
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hwrite,
    input  logic        hready_in,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        fsm_hready,
    input  logic [31:0] prdata,
    output logic        valid,
    output logic [2:0]  tempselx,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwrite_reg,
    output logic        hwrite_reg1,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hr_data
);

    typedef enum logic [1:0] {
        StOk   = 2'd0,
        StErr1 = 2'd1,
        StErr2 = 2'd2
    } state_e;

    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespError = 2'b01;

    state_e      state;
    logic [1:0]  hresp_q;
    logic        err_rdy_q;

    logic        active;
    logic        in_window;
    logic [31:0] offset;
    logic [31:0] region_idx;
    logic        aligned;
    logic        legal;
    logic        bad_xfer;

    // NONSEQ and SEQ only; IDLE and BUSY never start a transfer.
    assign active = ((htrans == 2'b10) || (htrans == 2'b11)) && hready_in;

    // Window check is done before the subtraction so a wrapped offset never selects a region.
    assign in_window  = (haddr >= ADDR_BASE);
    assign offset     = haddr - ADDR_BASE;
    assign region_idx = offset >> REGION_LOG2;

    always_comb begin
        tempselx = 3'b000;
        if (in_window) begin
            case (region_idx)
                32'd0:   tempselx = 3'b001;
                32'd1:   tempselx = 3'b010;
                32'd2:   tempselx = 3'b100;
                default: tempselx = 3'b000;
            endcase
        end
    end

`ifdef ALIGN_CHECK_EN
    always_comb begin
        aligned = 1'b1;
        if (hsize == 3'b001) begin
            aligned = (haddr[0] == 1'b0);
        end else if (hsize == 3'b010) begin
            aligned = (haddr[1:0] == 2'b00);
        end
    end
`else
    assign aligned = 1'b1;
`endif

    assign legal    = (hsize <= 3'b010) && aligned;
    assign bad_xfer = active && ((tempselx == 3'b000) || !legal);

    assign valid = active && (tempselx != 3'b000) && legal && (state == StOk) && !hreset;

    // Error FSM with registered response outputs.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= StOk;
            hresp_q   <= RespOkay;
            err_rdy_q <= 1'b0;
        end else begin
            case (state)
                StOk: begin
                    if (bad_xfer) begin
                        state     <= StErr1;
                        hresp_q   <= RespError;
                        err_rdy_q <= 1'b0;
                    end else begin
                        hresp_q   <= RespOkay;
                        err_rdy_q <= 1'b0;
                    end
                end
                StErr1: begin
                    state     <= StErr2;
                    hresp_q   <= RespError;
                    err_rdy_q <= 1'b1;
                end
                StErr2: begin
                    state     <= StOk;
                    hresp_q   <= RespOkay;
                    err_rdy_q <= 1'b0;
                end
                default: begin
                    state     <= StOk;
                    hresp_q   <= RespOkay;
                    err_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign hresp      = hresp_q;
    assign hready_out = (state == StOk) ? fsm_hready : err_rdy_q;

    // Pipelines advance together and freeze whenever the bus is stalled.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            haddr1      <= 32'h0;
            haddr2      <= 32'h0;
            hwdata1     <= 32'h0;
            hwdata2     <= 32'h0;
            hwrite_reg  <= 1'b0;
            hwrite_reg1 <= 1'b0;
        end else if (hready_in) begin
            haddr1      <= haddr;
            haddr2      <= haddr1;
            hwdata1     <= hwdata;
            hwdata2     <= hwdata1;
            hwrite_reg  <= hwrite;
            hwrite_reg1 <= hwrite_reg;
        end
    end

    assign hr_data = prdata;

endmodule
